// File: rtl/term_text_buf.sv
// Character store and cursor engine for the VGA text terminal.
// Bytes arrive over valid/ready; scrolling rotates a top-line offset instead of copying memory.
module term_text_buf #(
    parameter int          TERM_W = 70,
    parameter int          TERM_H = 30,
    parameter logic [7:0]  BLANK  = 8'h20
) (
    input  logic        clk_50M,
    input  logic        rst,
    input  logic [11:0] charidx,
    output logic [7:0]  char,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [6:0]  cursor_col,
    output logic [4:0]  cursor_row
);

    localparam int          N       = TERM_W * TERM_H;
    localparam logic [11:0] N12     = 12'(N);
    localparam logic [12:0] N13     = 13'(N);
    localparam logic [11:0] W12     = 12'(TERM_W);
    localparam logic [12:0] W13     = 13'(TERM_W);
    localparam logic [6:0]  W7      = 7'(TERM_W);
    localparam logic [6:0]  COL_MAX = 7'(TERM_W - 1);
    localparam logic [4:0]  ROW_MAX = 5'(TERM_H - 1);

    typedef enum logic [1:0] {
        CLR_ALL,
        IDLE,
        SCROLL,
        CLR_LINE
    } state_t;

    state_t      state, state_n;
    logic [6:0]  col, col_n;
    logic [4:0]  row, row_n;
    logic [11:0] top, top_n;
    logic [11:0] clr_addr, clr_addr_n;
    logic [6:0]  clr_cnt, clr_cnt_n;

    logic        we;
    logic [11:0] waddr;
    logic [7:0]  wdata;
    logic        do_lf;

    logic [7:0]  mem [0:N-1];

    logic [12:0] rd_sum;
    logic [11:0] rd_addr;
    logic [12:0] cur_sum;
    logic [11:0] cur_addr;
    logic [6:0]  tab_col;

    // Both operands are below N, so a single conditional subtraction wraps the sum.
    assign rd_sum   = {1'b0, charidx} + {1'b0, top};
    assign rd_addr  = (rd_sum >= N13) ? 12'(rd_sum - N13) : rd_sum[11:0];
    assign cur_sum  = {8'b0, row} * W13 + {6'b0, col} + {1'b0, top};
    assign cur_addr = (cur_sum >= N13) ? 12'(cur_sum - N13) : cur_sum[11:0];
    assign tab_col  = (col | 7'd7) + 7'd1;

    assign in_ready   = (state == IDLE);
    assign cursor_col = col;
    assign cursor_row = row;

    always_comb begin
        state_n    = state;
        col_n      = col;
        row_n      = row;
        top_n      = top;
        clr_addr_n = clr_addr;
        clr_cnt_n  = clr_cnt;
        we         = 1'b0;
        waddr      = clr_addr;
        wdata      = BLANK;
        do_lf      = 1'b0;
        case (state)
            CLR_ALL: begin
                we         = 1'b1;
                clr_addr_n = clr_addr + 12'd1;
                if (clr_addr == N12 - 12'd1) begin
                    state_n    = IDLE;
                    top_n      = 12'd0;
                    clr_addr_n = 12'd0;
                end
            end
            IDLE: begin
                if (in_valid) begin
                    if (in_data >= 8'h20) begin
                        we    = 1'b1;
                        waddr = cur_addr;
                        wdata = in_data;
                        if (col == COL_MAX) begin
                            col_n = 7'd0;
                            do_lf = 1'b1;
                        end else begin
                            col_n = col + 7'd1;
                        end
                    end else begin
                        case (in_data)
                            8'h0A: begin
                                col_n = 7'd0;
                                do_lf = 1'b1;
                            end
                            8'h0D: col_n = 7'd0;
                            8'h08: if (col != 7'd0) col_n = col - 7'd1;
                            8'h09: begin
                                if (tab_col >= W7) begin
                                    col_n = 7'd0;
                                    do_lf = 1'b1;
                                end else begin
                                    col_n = tab_col;
                                end
                            end
                            8'h0C: begin
                                col_n      = 7'd0;
                                row_n      = 5'd0;
                                clr_addr_n = 12'd0;
                                state_n    = CLR_ALL;
                            end
                            default: ;
                        endcase
                    end
                    if (do_lf) begin
                        if (row != ROW_MAX) row_n = row + 5'd1;
                        else                state_n = SCROLL;
                    end
                end
            end
            // The old top line becomes the new bottom line; blank its first cell here
            // so the whole line clear fits in term_w cycles.
            SCROLL: begin
                we         = 1'b1;
                waddr      = top;
                top_n      = (top >= N12 - W12) ? 12'd0 : top + W12;
                clr_addr_n = top + 12'd1;
                clr_cnt_n  = 7'd1;
                state_n    = CLR_LINE;
            end
            CLR_LINE: begin
                we         = 1'b1;
                clr_addr_n = clr_addr + 12'd1;
                clr_cnt_n  = clr_cnt + 7'd1;
                if (clr_cnt == COL_MAX) state_n = IDLE;
            end
            default: state_n = CLR_ALL;
        endcase
    end

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            state    <= CLR_ALL;
            col      <= 7'd0;
            row      <= 5'd0;
            top      <= 12'd0;
            clr_addr <= 12'd0;
            clr_cnt  <= 7'd0;
        end else begin
            state    <= state_n;
            col      <= col_n;
            row      <= row_n;
            top      <= top_n;
            clr_addr <= clr_addr_n;
            clr_cnt  <= clr_cnt_n;
        end
    end

    always_ff @(posedge clk_50M) begin
        if (we && !rst) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk_50M) begin
        if (rst) char <= 8'd0;
        else     char <= mem[rd_addr];
    end

endmodule

// File: tb/tb_term_text_buf.sv
// Directed self-checking bench for term_text_buf: clears, printing, control codes,
// scrolling with offset wrap, form feed and reset during a line clear.
module tb_term_text_buf;

    logic        clk_50M = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] charidx = 12'd0;
    logic [7:0]  char;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;

    int vec_count = 0;
    int fail_count = 0;
    int stall_total;
    int waited;
    int low_cycles;
    logic [7:0] rd;

    term_text_buf dut (
        .clk_50M    (clk_50M),
        .rst        (rst),
        .charidx    (charidx),
        .char       (char),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row)
    );

    always #10 clk_50M = ~clk_50M;

    task automatic tick();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Offer one byte and hold it until accepted; reports how many cycles it stalled.
    task automatic applyStimulus(input logic [7:0] b, output int stalls);
        stalls   = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && stalls < 5000) begin
            tick();
            stalls++;
        end
        if (stalls >= 5000) checkOutput("accept_timeout", 32'(stalls), 32'd0);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic sendRepeat(input logic [7:0] b, input int count, output int stall_sum);
        int s;
        stall_sum = 0;
        for (int i = 0; i < count; i++) begin
            applyStimulus(b, s);
            stall_sum += s;
        end
    endtask

    task automatic countReadyLow(output int n);
        n = 0;
        while (!in_ready && n < 5000) begin
            tick();
            n++;
        end
    endtask

    task automatic readCell(input int idx, output logic [7:0] value);
        charidx = 12'(idx);
        tick();
        value = char;
    endtask

    task automatic scanRange(input string tag, input int lo, input int hi, input logic [7:0] exp);
        int bad;
        logic [7:0] v;
        bad = 0;
        for (int i = lo; i <= hi; i++) begin
            readCell(i, v);
            if (v !== exp) bad++;
        end
        checkOutput(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        // Reset and power-on clear
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_char", 32'(char), 32'd0);
        checkOutput("rst_col", 32'(cursor_col), 32'd0);
        checkOutput("rst_row", 32'(cursor_row), 32'd0);
        countReadyLow(low_cycles);
        checkOutput("init_clear_cycles", 32'(low_cycles), 32'd2100);
        scanRange("init_scan_blank", 0, 2099, 8'h20);

        // Printable characters
        applyStimulus(8'h41, waited);
        applyStimulus(8'h42, waited);
        readCell(0, rd);
        checkOutput("cell0_A", 32'(rd), 32'h41);
        readCell(1, rd);
        checkOutput("cell1_B", 32'(rd), 32'h42);
        checkOutput("ab_col", 32'(cursor_col), 32'd2);
        checkOutput("ab_row", 32'(cursor_row), 32'd0);

        // Line wrap and TAB stops
        applyStimulus(8'h0D, waited);
        checkOutput("cr_col", 32'(cursor_col), 32'd0);
        sendRepeat(8'h78, 70, stall_total);
        checkOutput("wrap_stalls", 32'(stall_total), 32'd0);
        checkOutput("wrap_col", 32'(cursor_col), 32'd0);
        checkOutput("wrap_row", 32'(cursor_row), 32'd1);
        readCell(69, rd);
        checkOutput("cell69_x", 32'(rd), 32'h78);
        sendRepeat(8'h61, 3, stall_total);
        applyStimulus(8'h09, waited);
        checkOutput("tab3_col", 32'(cursor_col), 32'd8);
        sendRepeat(8'h09, 7, stall_total);
        checkOutput("tab64_col", 32'(cursor_col), 32'd64);
        sendRepeat(8'h62, 2, stall_total);
        applyStimulus(8'h09, waited);
        checkOutput("tab66_col", 32'(cursor_col), 32'd0);
        checkOutput("tab66_row", 32'(cursor_row), 32'd2);

        // Scroll: row 0 = 'Z', row 1 = 'B', then LF at the bottom line
        applyStimulus(8'h0C, waited);
        sendRepeat(8'h5A, 70, stall_total);
        sendRepeat(8'h42, 70, stall_total);
        checkOutput("fill_row", 32'(cursor_row), 32'd2);
        sendRepeat(8'h0A, 27, stall_total);
        checkOutput("bottom_row", 32'(cursor_row), 32'd29);
        applyStimulus(8'h0A, waited);
        countReadyLow(low_cycles);
        checkOutput("scroll_stall", 32'(low_cycles), 32'd70);
        checkOutput("scroll_col", 32'(cursor_col), 32'd0);
        checkOutput("scroll_row", 32'(cursor_row), 32'd29);
        scanRange("scroll_top_B", 0, 69, 8'h42);
        scanRange("scroll_bottom_blank", 2030, 2099, 8'h20);

        // Printable at the last column of the bottom line also scrolls
        sendRepeat(8'h71, 69, stall_total);
        applyStimulus(8'h72, waited);
        countReadyLow(low_cycles);
        checkOutput("wrap_scroll_stall", 32'(low_cycles), 32'd70);
        readCell(1960, rd);
        checkOutput("row28_q", 32'(rd), 32'h71);
        readCell(2029, rd);
        checkOutput("row28_r", 32'(rd), 32'h72);
        readCell(2030, rd);
        checkOutput("row29_blank", 32'(rd), 32'h20);

        // Backspace
        applyStimulus(8'h08, waited);
        checkOutput("bs0_col", 32'(cursor_col), 32'd0);
        checkOutput("bs0_row", 32'(cursor_row), 32'd29);
        sendRepeat(8'h6B, 5, stall_total);
        applyStimulus(8'h08, waited);
        checkOutput("bs5_col", 32'(cursor_col), 32'd4);
        readCell(2034, rd);
        checkOutput("bs_keeps_cell", 32'(rd), 32'h6B);
        applyStimulus(8'h01, waited);
        checkOutput("ctrl_ignored_col", 32'(cursor_col), 32'd4);

        // Form feed
        applyStimulus(8'h0C, waited);
        checkOutput("ff_col", 32'(cursor_col), 32'd0);
        checkOutput("ff_row", 32'(cursor_row), 32'd0);
        countReadyLow(low_cycles);
        checkOutput("ff_clear_cycles", 32'(low_cycles), 32'd2100);
        scanRange("ff_scan_blank", 0, 2099, 8'h20);

        // Reset in the middle of a line clear
        applyStimulus(8'h51, waited);
        sendRepeat(8'h0A, 29, stall_total);
        applyStimulus(8'h0A, waited);
        charidx = 12'd0;
        for (int i = 0; i < 20; i++) tick();
        checkOutput("mid_clear_busy", 32'(in_ready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst2_ready", 32'(in_ready), 32'd0);
        checkOutput("rst2_col", 32'(cursor_col), 32'd0);
        checkOutput("rst2_row", 32'(cursor_row), 32'd0);
        checkOutput("rst2_char", 32'(char), 32'd0);
        countReadyLow(low_cycles);
        checkOutput("rst2_clear_cycles", 32'(low_cycles), 32'd2100);
        scanRange("rst2_scan_blank", 0, 2099, 8'h20);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
        $finish;
    end

endmodule
